// File: rtl/des_pkg.sv
// Shared DES tables, permutation helpers and FSM state type for the iterative decrypt core.
// Bit 1 of every DES table maps to the MSB of the corresponding vector.
package des_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Right-rotation applied to C/D before each decrypt round; round 1 uses C0/D0 as-is.
    localparam int DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
        logic [27:0] y;
        case (n)
            1:       y = {x[0], x[27:1]};
            2:       y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/des_round.sv
// Single combinational Feistel round: L' = R, R' = L ^ P(S(E(R) ^ K)).
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l_i,
    input  logic [31:0] r_i,
    input  logic [47:0] subkey_i,
    output logic [31:0] l_o,
    output logic [31:0] r_o
);

    logic [47:0] mixed;
    logic [31:0] sOut;

    assign mixed = e_expand(r_i) ^ subkey_i;

    // S1 consumes the top six bits of the mixed word, S8 the bottom six.
    for (genvar g = 0; g < 8; g++) begin : gSbox
        des_sbox #(.IDX(g)) uSbox (
            .in_i  (mixed[47 - 6*g -: 6]),
            .out_o (sOut[31 - 4*g -: 4])
        );
    end

    assign l_o = r_i;
    assign r_o = l_i ^ p_perm(sOut);

endmodule

// File: rtl/des_sbox.sv
// One DES S-box: 6-bit input (outer bits select row, inner bits column) to 4-bit output.
module des_sbox
    import des_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic [5:0] in_i,
    output logic [3:0] out_o
);

    assign out_o = SBOX[IDX][{in_i[5], in_i[0], in_i[4:1]}];

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decrypt engine: ROUNDS_PER_CLK Feistel rounds per clock, subkeys K16..K1
// derived on the fly by right-rotating C/D, valid/ready handshakes on both sides.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CLK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out
);

    if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2) begin : gBadParam
        $error("des_decrypt_iter: ROUNDS_PER_CLK must be 1 or 2");
    end

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [63:0] dataOut_q, dataOut_d;
    logic        outValid_q, outValid_d;

    logic [31:0] chainL [ROUNDS_PER_CLK+1];
    logic [31:0] chainR [ROUNDS_PER_CLK+1];
    logic [27:0] chainC [ROUNDS_PER_CLK+1];
    logic [27:0] chainD [ROUNDS_PER_CLK+1];

    assign chainL[0] = l_q;
    assign chainR[0] = r_q;
    assign chainC[0] = c_q;
    assign chainD[0] = d_q;

    // Each stage rotates C/D for its own round index before forming the subkey.
    for (genvar g = 0; g < ROUNDS_PER_CLK; g++) begin : gRound
        logic [3:0]  roundIdx;
        logic [47:0] subkey;

        assign roundIdx      = cnt_q[3:0] + 4'(g);
        assign chainC[g+1]   = rotr28(chainC[g], DEC_SHIFT[roundIdx]);
        assign chainD[g+1]   = rotr28(chainD[g], DEC_SHIFT[roundIdx]);
        assign subkey        = pc2_perm({chainC[g+1], chainD[g+1]});

        des_round uRound (
            .l_i      (chainL[g]),
            .r_i      (chainR[g]),
            .subkey_i (subkey),
            .l_o      (chainL[g+1]),
            .r_o      (chainR[g+1])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        l_d        = l_q;
        r_d        = r_q;
        c_d        = c_q;
        d_d        = d_q;
        dataOut_d  = dataOut_q;
        outValid_d = outValid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    {l_d, r_d} = ip_perm(data_in);
                    {c_d, d_d} = pc1_perm(key);
                    cnt_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Once all 16 rounds are in, spend one more clock on the final permutation.
                if (cnt_q == 5'd16) begin
                    dataOut_d  = fp_perm({r_q, l_q});
                    outValid_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    l_d   = chainL[ROUNDS_PER_CLK];
                    r_d   = chainR[ROUNDS_PER_CLK];
                    c_d   = chainC[ROUNDS_PER_CLK];
                    d_d   = chainD[ROUNDS_PER_CLK];
                    cnt_d = cnt_q + 5'(ROUNDS_PER_CLK);
                end
            end
            DONE: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            dataOut_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            l_q        <= l_d;
            r_q        <= r_d;
            c_q        <= c_d;
            d_q        <= d_d;
            dataOut_q  <= dataOut_d;
            outValid_q <= outValid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = outValid_q;
    assign data_out  = dataOut_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter: one instance per legal ROUNDS_PER_CLK,
// known DES vectors, latency, hold, reset-abort and back-to-back spacing.
module tb_des_decrypt_iter;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY2 = 64'h0000000000000000;
    localparam logic [63:0] CT2  = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] PT2  = 64'h0000000000000000;
    localparam logic [63:0] KEY3 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] CT3  = 64'h0000000000000000;
    localparam logic [63:0] PT3  = 64'h8787878787878787;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid  [2];
    logic        inReady  [2];
    logic [63:0] dataIn   [2];
    logic [63:0] keyIn    [2];
    logic        outValid [2];
    logic        outReady [2];
    logic [63:0] dataOut  [2];

    int testsRun    = 0;
    int testsFailed = 0;

    logic [63:0] vecKey [3];
    logic [63:0] vecCt  [3];
    logic [63:0] vecPt  [3];

    always #5 clk = ~clk;

    des_decrypt_iter #(.ROUNDS_PER_CLK(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(inValid[0]), .in_ready(inReady[0]),
        .data_in(dataIn[0]), .key(keyIn[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .data_out(dataOut[0])
    );

    des_decrypt_iter #(.ROUNDS_PER_CLK(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(inValid[1]), .in_ready(inReady[1]),
        .data_in(dataIn[1]), .key(keyIn[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .data_out(dataOut[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Presents a block and returns just after the edge on which it was accepted.
    task automatic applyStimulus(input int sel, input logic [63:0] k, input logic [63:0] d,
                                 output time acceptTime);
        int waitCnt = 0;
        @(negedge clk);
        keyIn[sel]   = k;
        dataIn[sel]  = d;
        inValid[sel] = 1'b1;
        while (!inReady[sel] && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("acceptReady", 64'(inReady[sel]), 64'd1);
        @(posedge clk);
        acceptTime = $time;
        #1;
        inValid[sel] = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid is seen; optionally scrambles inputs meanwhile.
    task automatic waitResult(input int sel, input bit toggle, output int lat);
        lat = 0;
        do begin
            if (toggle) begin
                @(negedge clk);
                keyIn[sel]  = {$urandom, $urandom};
                dataIn[sel] = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            lat++;
        end while (!outValid[sel] && lat < 40);
        checkOutput("outValidSeen", 64'(outValid[sel]), 64'd1);
    endtask

    task automatic releaseOutput(input int sel);
        @(negedge clk);
        outReady[sel] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("outValidDrop", 64'(outValid[sel]), 64'd0);
        checkOutput("inReadyBack", 64'(inReady[sel]), 64'd1);
        outReady[sel] = 1'b0;
    endtask

    initial begin
        time acc;
        time accTimes [3];
        int  lat;

        vecKey = '{KEY1, KEY2, KEY3};
        vecCt  = '{CT1, CT2, CT3};
        vecPt  = '{PT1, PT2, PT3};
        for (int s = 0; s < 2; s++) begin
            inValid[s]  = 1'b0;
            outReady[s] = 1'b0;
            dataIn[s]   = '0;
            keyIn[s]    = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput("rstDataOut", dataOut[s], 64'd0);
            checkOutput("rstOutValid", 64'(outValid[s]), 64'd0);
            checkOutput("rstInReady", 64'(inReady[s]), 64'd1);
        end
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(0, KEY1, CT1, acc);
        waitResult(0, 1'b0, lat);
        checkOutput("v1Latency", 64'(lat), 64'd17);
        checkOutput("v1Data", dataOut[0], PT1);
        releaseOutput(0);

        applyStimulus(0, KEY2, CT2, acc);
        waitResult(0, 1'b0, lat);
        checkOutput("v2Data", dataOut[0], PT2);
        releaseOutput(0);

        applyStimulus(0, KEY3, CT3, acc);
        waitResult(0, 1'b0, lat);
        checkOutput("v3Data", dataOut[0], PT3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("v3HoldData", dataOut[0], PT3);
            checkOutput("v3HoldInReady", 64'(inReady[0]), 64'd0);
            checkOutput("v3HoldValid", 64'(outValid[0]), 64'd1);
        end
        releaseOutput(0);

        applyStimulus(0, KEY1, CT1, acc);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abortOutValid", 64'(outValid[0]), 64'd0);
        checkOutput("abortInReady", 64'(inReady[0]), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("abortEdgeOutValid", 64'(outValid[0]), 64'd0);
        checkOutput("abortEdgeInReady", 64'(inReady[0]), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, KEY2, CT2, acc);
        waitResult(0, 1'b0, lat);
        checkOutput("afterAbortData", dataOut[0], PT2);
        releaseOutput(0);

        applyStimulus(0, KEY1, CT1, acc);
        waitResult(0, 1'b1, lat);
        checkOutput("toggleLatency", 64'(lat), 64'd17);
        checkOutput("toggleData", dataOut[0], PT1);
        releaseOutput(0);

        outReady[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, vecKey[i], vecCt[i], accTimes[i]);
            waitResult(0, 1'b0, lat);
            checkOutput("b2bData", dataOut[0], vecPt[i]);
        end
        checkOutput("b2bSpacing01", 64'((accTimes[1] - accTimes[0]) / 10), 64'd19);
        checkOutput("b2bSpacing12", 64'((accTimes[2] - accTimes[1]) / 10), 64'd19);
        @(negedge clk);
        outReady[0] = 1'b0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, vecKey[i], vecCt[i], acc);
            waitResult(1, 1'b0, lat);
            checkOutput("r2Latency", 64'(lat), 64'd9);
            checkOutput("r2Data", dataOut[1], vecPt[i]);
            releaseOutput(1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
